cook_ctrl: RTL and testbench
============================

COOK_CTRL -- requirements
Module: cook_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports startn, stopn and clearn, input, 1 each, active-low front-panel commands, sampled synchronously as levels.
REQ-004 SHALL have port door_closed, input, 1, high when the door is shut.
REQ-005 SHALL have ports key_valid, input, 1, and key_code, input, 4: digit entry strobe plus value.
REQ-006 SHALL have port tick_1hz, input, 1, one-cycle pulse per second.
REQ-007 SHALL have ports min_tens, min_units, sec_tens and sec_units, output, 4 each, BCD remaining time MM:SS.
REQ-008 SHALL have port mag_on, output, 1, magnetron enable.
REQ-009 SHALL have port timer_done, output, 1, cook-complete flag.
REQ-010 SHALL have port state_o, output, 3, current state encoding, for debug.

Function
REQ-011 SHALL implement states IDLE, ENTRY, COOK, PAUSE, DONE.
REQ-012 Command priority SHALL be clearn > door open > stopn > startn > key_valid > tick_1hz.
REQ-013 clearn low in any state SHALL give IDLE and all digits 0 on the next edge.
REQ-014 key_valid with key_code <= 9 in IDLE, ENTRY or PAUSE SHALL shift left: min_tens<-min_units, min_units<-sec_tens, sec_tens<-sec_units, sec_units<-key_code; state SHALL become ENTRY, or stay PAUSE when paused.
REQ-015 key_code > 9, or any key in COOK or DONE, SHALL be ignored.
REQ-016 startn low with door_closed=1 and time != 0000 in IDLE, ENTRY or PAUSE SHALL give COOK; otherwise start SHALL be ignored.
REQ-017 In COOK, tick_1hz SHALL decrement the time: if SS=00 then SS<-59 and MM<-MM-1, else SS<-SS-1 in BCD. Sec_tens values 6-9 entered by key SHALL count down normally, e.g. 0090 -> 0089.
REQ-018 In COOK, a tick at time 0001 SHALL set time 0000 and state DONE on the same edge.
REQ-019 In COOK, door_closed=0 or stopn low SHALL give PAUSE with time frozen; a simultaneous tick SHALL NOT decrement.
REQ-020 In PAUSE, ticks SHALL be ignored, and stopn SHALL have no effect.
REQ-021 In DONE, the next clearn low or door opening SHALL give IDLE.
REQ-022 mag_on SHALL equal 1 exactly in cycles where the state register is COOK, decoded from registered state with no input-to-output combinational path.
REQ-023 timer_done SHALL equal 1 exactly in cycles where the state register is DONE.
REQ-024 mag_on and timer_done SHALL never both be 1.

Reset
REQ-025 rst SHALL asynchronously force IDLE, all digits 0, mag_on=0 and timer_done=0.
REQ-026 Reset asserted mid-COOK SHALL drop mag_on immediately, without waiting for clk.
REQ-027 After rst deasserts, the first edge SHALL evaluate inputs normally.

Structure
REQ-028 A shared package cook_pkg SHALL hold the state encodings (3-bit), the BCD digit width (4) and constants SEC_MAX_TENS=5 and SEC_MAX_UNITS=9.
REQ-029 One sub-module, bcd_mmss_down, SHALL hold the four digit registers, the load/shift and decrement logic, and a zero flag.
REQ-030 The FSM SHALL live in cook_ctrl.

Verification
REQ-031 Reset, keys 1,3,0, then startn with door closed -> digits 01:30 and mag_on=1 the next cycle; after 90 ticks -> 00:00, DONE, timer_done=1, mag_on=0.
REQ-032 Time 00:02 in COOK, door opens on a tick cycle -> PAUSE with 00:02 held and mag_on=0; door closes, startn -> COOK, and after 2 ticks -> DONE.
REQ-033 Time 01:00, one tick -> 00:59; time 00:90, one tick -> 00:89.
REQ-034 startn with time 0000, or with door_closed=0 -> stays IDLE/ENTRY, mag_on=0; key_code=12 -> digits unchanged.
REQ-035 COOK at 05:00 with clearn and startn low together -> IDLE, 00:00, mag_on=0.
REQ-036 rst pulsed asynchronously mid-COOK -> mag_on=0 before the next clk edge and digits 0.

Source files
------------

// File: rtl/cook_pkg.sv
// Shared definitions for the cooking-timer controller.
//   state_t        : 3-bit FSM state encoding (also exported on state_o)
//   DIGIT_W        : width of one BCD digit
//   SEC_MAX_*      : digit values loaded when the seconds field borrows (SS 00 -> 59)
//   KEY_MAX        : largest key code that is a digit; larger codes are ignored
package cook_pkg;
   localparam int DIGIT_W       = 4;
   localparam int SEC_MAX_TENS  = 5;
   localparam int SEC_MAX_UNITS = 9;
   localparam int KEY_MAX       = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_COOK  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/bcd_mmss_down.sv
// Four-digit BCD MM:SS register with key shift-in and one-second countdown.
//   clk, rst        : clock, async active-high reset (all digits 0)
//   clr             : synchronous clear to 00:00 (highest priority)
//   shift_en, key   : shift digits left, key enters at sec_units
//   dec_en          : decrement MM:SS by one second
//   min_tens..sec_units : current digits
//   zero            : time is 00:00
//   last            : time is 00:01 (next decrement reaches zero)
module bcd_mmss_down
   import cook_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift_en,
   input  logic [DIGIT_W-1:0] key,
   input  logic               dec_en,
   output logic [DIGIT_W-1:0] min_tens,
   output logic [DIGIT_W-1:0] min_units,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] sec_units,
   output logic               zero,
   output logic               last
);
   localparam logic [DIGIT_W-1:0] D0 = '0;
   localparam logic [DIGIT_W-1:0] D1 = DIGIT_W'(1);
   localparam logic [DIGIT_W-1:0] D9 = DIGIT_W'(9);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_tens  <= D0;
         min_units <= D0;
         sec_tens  <= D0;
         sec_units <= D0;
      end else if (clr) begin
         min_tens  <= D0;
         min_units <= D0;
         sec_tens  <= D0;
         sec_units <= D0;
      end else if (shift_en) begin
         min_tens  <= min_units;
         min_units <= sec_tens;
         sec_tens  <= sec_units;
         sec_units <= key;
      end else if (dec_en) begin
         if (sec_tens == D0 && sec_units == D0) begin
            sec_tens  <= DIGIT_W'(SEC_MAX_TENS);
            sec_units <= DIGIT_W'(SEC_MAX_UNITS);
            if (min_units == D0) begin
               min_units <= D9;
               min_tens  <= min_tens - D1;
            end else begin
               min_units <= min_units - D1;
            end
         end else if (sec_units == D0) begin
            // Keyed sec_tens of 6..9 borrow like any other digit: 90 -> 89
            sec_units <= D9;
            sec_tens  <= sec_tens - D1;
         end else begin
            sec_units <= sec_units - D1;
         end
      end
   end

   assign zero = {min_tens, min_units, sec_tens, sec_units} == '0;
   assign last = {min_tens, min_units, sec_tens} == '0 && sec_units == D1;
endmodule

// File: rtl/cook_ctrl.sv
// Front-panel cooking timer FSM (IDLE/ENTRY/COOK/PAUSE/DONE).
//   clk, rst                 : clock, async active-high reset
//   startn, stopn, clearn    : active-low panel commands (levels)
//   door_closed              : 1 when door shut
//   key_valid, key_code      : digit entry
//   tick_1hz                 : one-cycle pulse per second
//   min_tens..sec_units      : BCD remaining time MM:SS
//   mag_on, timer_done       : decoded from registered state only
//   state_o                  : state encoding for debug
// A command that has no effect in the current state does not block a
// lower-priority one (e.g. a refused start lets a key through).
module cook_ctrl
   import cook_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         startn,
   input  logic         stopn,
   input  logic         clearn,
   input  logic         door_closed,
   input  logic         key_valid,
   input  logic [3:0]   key_code,
   input  logic         tick_1hz,
   output logic [3:0]   min_tens,
   output logic [3:0]   min_units,
   output logic [3:0]   sec_tens,
   output logic [3:0]   sec_units,
   output logic         mag_on,
   output logic         timer_done,
   output logic [2:0]   state_o
);
   state_t state, state_nxt;
   logic   clr, shift_en, dec_en, zero, last;

   bcd_mmss_down u_time (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .shift_en  (shift_en),
      .key       (key_code),
      .dec_en    (dec_en),
      .min_tens  (min_tens),
      .min_units (min_units),
      .sec_tens  (sec_tens),
      .sec_units (sec_units),
      .zero      (zero),
      .last      (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      shift_en  = 1'b0;
      dec_en    = 1'b0;
      if (!clearn) begin
         state_nxt = ST_IDLE;
         clr       = 1'b1;
      end else begin
         case (state)
            ST_COOK: begin
               // Door/stop freeze the time even on a tick cycle
               if (!door_closed || !stopn) begin
                  state_nxt = ST_PAUSE;
               end else if (tick_1hz) begin
                  dec_en = 1'b1;
                  if (last) state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               if (!door_closed) state_nxt = ST_IDLE;
            end
            default: begin // IDLE, ENTRY, PAUSE
               if (!startn && door_closed && !zero) begin
                  state_nxt = ST_COOK;
               end else if (key_valid && key_code <= 4'(KEY_MAX)) begin
                  shift_en = 1'b1;
                  if (state != ST_PAUSE) state_nxt = ST_ENTRY;
               end
            end
         endcase
      end
   end

   assign mag_on     = (state == ST_COOK);
   assign timer_done = (state == ST_DONE);
   assign state_o    = state;
endmodule

// File: tb/tb_cook_ctrl.sv
module tb_cook_ctrl;
   import cook_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
   logic       key_valid = 1'b0, tick_1hz = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic       mag_on, timer_done;
   logic [2:0] state_o;

   int errors = 0, checks = 0;

   // reference model: state as enum value, time as four decimal digits
   int m_st;
   int md[4];

   cook_ctrl dut (
      .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
      .door_closed(door_closed), .key_valid(key_valid), .key_code(key_code),
      .tick_1hz(tick_1hz), .min_tens(min_tens), .min_units(min_units),
      .sec_tens(sec_tens), .sec_units(sec_units), .mag_on(mag_on),
      .timer_done(timer_done), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {min_tens, min_units, sec_tens, sec_units};
   endfunction

   function automatic logic [15:0] m_digits();
      return {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
   endfunction

   task automatic model_reset();
      m_st = int'(ST_IDLE);
      for (int i = 0; i < 4; i++) md[i] = 0;
   endtask

   // next state from the current inputs, evaluated by the rules in priority order
   task automatic model_step();
      int  mm, ss;
      bit  is_zero;
      is_zero = (md[0] + md[1] + md[2] + md[3]) == 0;
      if (!clearn) begin
         model_reset();
      end else if (m_st == int'(ST_COOK)) begin
         if (!door_closed || !stopn) m_st = int'(ST_PAUSE);
         else if (tick_1hz) begin
            mm = md[0] * 10 + md[1];
            ss = md[2] * 10 + md[3];
            if (ss == 0) begin ss = 59; mm = mm - 1; end
            else ss = ss - 1;
            md[0] = mm / 10; md[1] = mm % 10;
            md[2] = ss / 10; md[3] = ss % 10;
            if (mm == 0 && ss == 0) m_st = int'(ST_DONE);
         end
      end else if (m_st == int'(ST_DONE)) begin
         if (!door_closed) m_st = int'(ST_IDLE);
      end else begin
         if (!startn && door_closed && !is_zero) m_st = int'(ST_COOK);
         else if (key_valid && key_code < 10) begin
            md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = int'(key_code);
            if (m_st != int'(ST_PAUSE)) m_st = int'(ST_ENTRY);
         end
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, "_time"}, 32'(digits()), 32'(m_digits()));
      chk({tag, "_state"}, 32'(state_o), 32'(m_st));
      chk({tag, "_mag"}, 32'(mag_on), 32'(m_st == int'(ST_COOK)));
      chk({tag, "_done"}, 32'(timer_done), 32'(m_st == int'(ST_DONE)));
      chk({tag, "_excl"}, 32'(mag_on & timer_done), 32'd0);
   endtask

   task automatic cyc(string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic key(int code, string tag);
      key_valid = 1'b1; key_code = 4'(code);
      cyc(tag);
      key_valid = 1'b0;
   endtask

   task automatic tick(string tag);
      tick_1hz = 1'b1; cyc(tag);
      tick_1hz = 1'b0; cyc(tag);
   endtask

   task automatic start(string tag);
      startn = 1'b0; cyc(tag); startn = 1'b1;
   endtask

   task automatic clear(string tag);
      clearn = 1'b0; cyc(tag); clearn = 1'b1;
   endtask

   initial begin
      // reset
      model_reset();
      #12;
      chk("rst_time", 32'(digits()), 32'h0);
      chk("rst_state", 32'(state_o), 32'(ST_IDLE));
      chk("rst_mag", 32'(mag_on), 32'd0);
      chk("rst_done", 32'(timer_done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc("idle");

      // 01:30 full cook
      key(1, "k1"); key(3, "k3"); key(0, "k0");
      chk("r031_entry", 32'(digits()), 32'h0130);
      start("r031_start");
      chk("r031_mag", 32'(mag_on), 32'd1);
      for (int i = 0; i < 90; i++) tick("r031_tick");
      chk("r031_end_time", 32'(digits()), 32'h0000);
      chk("r031_end_state", 32'(state_o), 32'(ST_DONE));
      chk("r031_end_done", 32'(timer_done), 32'd1);
      chk("r031_end_mag", 32'(mag_on), 32'd0);
      tick("done_tick");
      clear("clr1");

      // door opens on a tick at 00:02
      key(2, "k2"); start("r032_start");
      door_closed = 1'b0; tick_1hz = 1'b1; cyc("r032_door");
      tick_1hz = 1'b0;
      chk("r032_pause_time", 32'(digits()), 32'h0002);
      chk("r032_pause_state", 32'(state_o), 32'(ST_PAUSE));
      chk("r032_pause_mag", 32'(mag_on), 32'd0);
      tick("r032_pause_tick");
      door_closed = 1'b1; cyc("r032_close");
      start("r032_restart");
      tick("r032_t1"); tick("r032_t2");
      chk("r032_end_state", 32'(state_o), 32'(ST_DONE));
      door_closed = 1'b0; cyc("done_door");
      door_closed = 1'b1;
      chk("done_door_state", 32'(state_o), 32'(ST_IDLE));

      // borrow cases
      clear("clr2");
      key(1, "k"); key(0, "k"); key(0, "k"); start("r033a_start");
      tick("r033a_tick");
      chk("r033a_time", 32'(digits()), 32'h0059);
      clear("clr3");
      key(9, "k"); key(0, "k"); start("r033b_start");
      tick("r033b_tick");
      chk("r033b_time", 32'(digits()), 32'h0089);

      // refused starts and invalid key
      clear("clr4");
      start("r034_zero");
      chk("r034_zero_state", 32'(state_o), 32'(ST_IDLE));
      key(5, "k5");
      door_closed = 1'b0; start("r034_door"); door_closed = 1'b1;
      chk("r034_door_state", 32'(state_o), 32'(ST_ENTRY));
      chk("r034_door_mag", 32'(mag_on), 32'd0);
      key(12, "r034_k12");
      chk("r034_k12_time", 32'(digits()), 32'h0005);

      // clear beats start while cooking
      clear("clr5");
      key(5, "k"); key(0, "k"); key(0, "k"); start("r035_start");
      clearn = 1'b0; startn = 1'b0; cyc("r035_both");
      clearn = 1'b1; startn = 1'b1;
      chk("r035_time", 32'(digits()), 32'h0);
      chk("r035_state", 32'(state_o), 32'(ST_IDLE));

      // async reset mid-cook
      key(4, "k"); start("r036_start");
      tick("r036_tick");
      #3 rst = 1'b1;
      #1;
      chk("r036_mag", 32'(mag_on), 32'd0);
      chk("r036_time", 32'(digits()), 32'h0);
      chk("r036_state", 32'(state_o), 32'(ST_IDLE));
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      key(7, "r027_key");

      // random
      for (int i = 0; i < 3000; i++) begin
         clearn      = ($urandom_range(39) != 0);
         door_closed = ($urandom_range(9) != 0);
         stopn       = ($urandom_range(14) != 0);
         startn      = ($urandom_range(5) != 0);
         key_valid   = ($urandom_range(2) == 0);
         key_code    = 4'($urandom_range(15));
         tick_1hz    = 1'($urandom_range(1));
         cyc("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
